// File: rtl/fast_nms_3x3.sv
// rtl/fast_nms_3x3.sv - 3x3 non-maximum suppression of FAST corner scores with FWFT keypoint FIFO
// Raster-order tie-break: strict > against predecessors, >= against successors.
module fast_nms_3x3 #(
  parameter int COL_NUM    = 640,
  parameter int ROW_NUM    = 480,
  parameter int SCORE_W    = 13,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               in_vld,
  input  logic               iscorner,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         x_coord,
  input  logic [9:0]         y_coord,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [9:0]         out_x,
  output logic [9:0]         out_y,
  output logic [SCORE_W-1:0] out_score,
  output logic               overflow,
  output logic [15:0]        drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(COL_NUM);
  localparam logic [9:0] X_MAX = 10'(COL_NUM - 1);
  localparam logic [9:0] Y_MAX = 10'(ROW_NUM - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic               accept;
  logic [SCORE_W-1:0] s_eff;
  logic [LW-1:0]      lb_idx;
  logic [SCORE_W-1:0] lb1_rd;
  logic [SCORE_W-1:0] lb2_rd;
  logic               elig;

  assign accept = ce & in_vld;
  assign s_eff  = iscorner ? score : '0;
  assign lb_idx = x_coord[LW-1:0];
  assign elig   = (x_coord >= 10'd2) && (y_coord >= 10'd2) &&
                  (x_coord <= X_MAX) && (y_coord <= Y_MAX);

  // Line buffers carry no reset; stale rows are masked by the eligibility flag.
  logic [SCORE_W-1:0] lb1 [COL_NUM];
  logic [SCORE_W-1:0] lb2 [COL_NUM];

  assign lb1_rd = lb1[lb_idx];
  assign lb2_rd = lb2[lb_idx];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[lb_idx] <= lb1_rd;
      lb1[lb_idx] <= s_eff;
    end
  end

  // Stage 1: window rows are [0]=y-2, [1]=y-1, [2]=y; columns [0]=x-2 .. [2]=x.
  logic [SCORE_W-1:0] win [3][3];
  logic               v1;
  logic [9:0]         cx1;
  logic [9:0]         cy1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
      v1  <= 1'b0;
      cx1 <= '0;
      cy1 <= '0;
    end else begin
      if (ce) begin
        v1 <= in_vld & elig;
      end
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= s_eff;
        cx1 <= x_coord - 10'd1;
        cy1 <= y_coord - 10'd1;
      end
    end
  end

  logic [SCORE_W-1:0] cen;
  logic               keep_c;

  assign cen = win[1][1];

  always_comb begin
    keep_c = 1'b0;
    if (cen != '0) begin
      keep_c = (cen >  win[0][0]) && (cen >  win[0][1]) && (cen >  win[0][2]) &&
               (cen >  win[1][0]) && (cen >= win[1][2]) && (cen >= win[2][0]) &&
               (cen >= win[2][1]) && (cen >= win[2][2]);
    end
  end

  // Stage 2: registered keep decision.
  logic               keep2;
  logic [9:0]         kx;
  logic [9:0]         ky;
  logic [SCORE_W-1:0] ks;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keep2 <= 1'b0;
      kx    <= '0;
      ky    <= '0;
      ks    <= '0;
    end else if (ce) begin
      keep2 <= v1 & keep_c;
      kx    <= cx1;
      ky    <= cy1;
      ks    <= cen;
    end
  end

  // Stage 3: first-word-fall-through FIFO.
  logic [9:0]         fx [FIFO_DEPTH];
  logic [9:0]         fy [FIFO_DEPTH];
  logic [SCORE_W-1:0] fs [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               wr_req;
  logic               pop;
  logic               full;
  logic               wr_ok;

  assign out_vld = (count != '0);
  assign pop     = out_vld & out_rdy;
  assign full    = (count == FULL_CNT);
  assign wr_req  = ce & keep2;
  assign wr_ok   = wr_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      fx[wr_ptr] <= kx;
      fy[wr_ptr] <= ky;
      fs[wr_ptr] <= ks;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_req && full && !pop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

  // Gate the head with out_vld so outputs read zero from reset without clearing storage.
  assign out_x     = out_vld ? fx[rd_ptr] : '0;
  assign out_y     = out_vld ? fy[rd_ptr] : '0;
  assign out_score = out_vld ? fs[rd_ptr] : '0;

endmodule

// File: tb/tb_fast_nms_3x3.sv
// tb/tb_fast_nms_3x3.sv - scoreboard bench for fast_nms_3x3 on a reduced 32x16 frame
module tb_fast_nms_3x3;

  localparam int COLS  = 32;
  localparam int ROWS  = 16;
  localparam int SW    = 13;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          ce;
  logic          in_vld;
  logic          iscorner;
  logic [SW-1:0] score;
  logic [9:0]    x_coord;
  logic [9:0]    y_coord;
  logic          out_vld;
  logic          out_rdy;
  logic [9:0]    out_x;
  logic [9:0]    out_y;
  logic [SW-1:0] out_score;
  logic          overflow;
  logic [15:0]   drop_cnt;

  fast_nms_3x3 #(
    .COL_NUM(COLS), .ROW_NUM(ROWS), .SCORE_W(SW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld), .iscorner(iscorner),
    .score(score), .x_coord(x_coord), .y_coord(y_coord), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_x(out_x), .out_y(out_y), .out_score(out_score),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]    x;
    logic [9:0]    y;
    logic [SW-1:0] s;
  } kp_t;

  kp_t           exp_q[$];
  kp_t           head;
  int            checks = 0;
  int            errors = 0;
  logic [SW-1:0] img [ROWS][COLS];
  bit            cmap [ROWS][COLS];
  event          lat_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_vld && out_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_kp actual (%0d,%0d,%0d) required none", out_x, out_y, out_score);
      end else begin
        head = exp_q.pop_front();
        if (out_x !== head.x || out_y !== head.y || out_score !== head.s) begin
          errors++;
          $display("FAIL kp actual (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                   out_x, out_y, out_score, head.x, head.y, head.s);
        end
      end
    end
  end

  initial begin
    forever begin
      @(lat_ev);
      @(posedge clk); #1;
      check("lat_e1_low", {31'd0, out_vld}, 32'd0);
      @(posedge clk); #1;
      check("lat_e2_high", {31'd0, out_vld}, 32'd1);
    end
  end

  task automatic clear_img();
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        cmap[y][x] = 1'b0;
        img[y][x]  = SW'($urandom_range(1, 8000));
      end
    end
  endtask

  task automatic set_c(input int x, input int y, input int s);
    cmap[y][x] = 1'b1;
    img[y][x]  = SW'(s);
  endtask

  task automatic push_exp(input int x, input int y, input int s);
    kp_t k;
    k.x = 10'(x);
    k.y = 10'(y);
    k.s = SW'(s);
    exp_q.push_back(k);
  endtask

  task automatic frame_a();
    clear_img();
    set_c(10, 10, 100);
    set_c(20, 5, 50);  set_c(21, 5, 50);
    set_c(30, 8, 50);  set_c(30, 9, 50);
    set_c(0, 3, 200);  set_c(31, 3, 200);
    set_c(5, 0, 200);  set_c(5, 15, 200);
    set_c(1, 1, 200);
  endtask

  task automatic frame_b();
    clear_img();
    for (int i = 0; i < 6; i++) set_c(3 + 5 * i, 3, 10 * (i + 1));
  endtask

  task automatic stream(input int stop_idx, input int gap_at, input bit lat_on);
    int x;
    int y;
    for (int idx = 0; idx < stop_idx; idx++) begin
      x = idx % COLS;
      y = idx / COLS;
      iscorner = cmap[y][x];
      score    = img[y][x];
      x_coord  = 10'(x);
      y_coord  = 10'(y);
      in_vld   = 1'b1;
      if (idx == gap_at) begin
        ce = 1'b0;
        repeat (5) @(posedge clk);
        #1;
      end
      ce = 1'b1;
      @(posedge clk); #1;
      if (lat_on && x == 11 && y == 11) -> lat_ev;
    end
    in_vld   = 1'b0;
    iscorner = 1'b0;
    score    = '0;
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_vld_low"}, {31'd0, out_vld}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; in_vld = 1'b0; iscorner = 1'b0; score = '0;
    x_coord = '0; y_coord = '0; out_rdy = 1'b0;
    #12;
    check("rst_out_vld", {31'd0, out_vld}, 32'd0);
    check("rst_out_x", {22'd0, out_x}, 32'd0);
    check("rst_out_y", {22'd0, out_y}, 32'd0);
    check("rst_out_score", {19'd0, out_score}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Clean frame: isolated, ties, border ring, corner next to border.
    out_rdy = 1'b1;
    frame_a();
    push_exp(1, 1, 200); push_exp(20, 5, 50); push_exp(30, 8, 50); push_exp(10, 10, 100);
    stream(ROWS * COLS, -1, 1'b1);
    drain("frame_a_drain", 200);
    check("frame_a_overflow", {31'd0, overflow}, 32'd0);

    // Backpressure: four of six survivors held, two dropped.
    out_rdy = 1'b0;
    frame_b();
    push_exp(3, 3, 10); push_exp(8, 3, 20); push_exp(13, 3, 30); push_exp(18, 3, 40);
    stream(ROWS * COLS, -1, 1'b0);
    ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ovf_overflow", {31'd0, overflow}, 32'd1);
    check("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd2);
    check("ovf_out_vld", {31'd0, out_vld}, 32'd1);
    check("ovf_hold_x", {22'd0, out_x}, 32'd3);
    check("ovf_hold_y", {22'd0, out_y}, 32'd3);
    check("ovf_hold_score", {19'd0, out_score}, 32'd10);
    out_rdy = 1'b1;
    drain("ovf_drain", 50);

    // Async reset with three keypoints queued.
    out_rdy = 1'b0;
    frame_b();
    stream(4 * COLS + 15, -1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_out_vld", {31'd0, out_vld}, 32'd1);
    check("pre_rst_drop_cnt", {16'd0, drop_cnt}, 32'd2);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out_vld", {31'd0, out_vld}, 32'd0);
    check("mid_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    check("mid_rst_out_x", {22'd0, out_x}, 32'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;

    // Same clean frame after reset, with a five-cycle ce gap mid-row.
    out_rdy = 1'b1;
    frame_a();
    push_exp(1, 1, 200); push_exp(20, 5, 50); push_exp(30, 8, 50); push_exp(10, 10, 100);
    stream(ROWS * COLS, 10 * COLS + 12, 1'b0);
    drain("ce_gap_drain", 200);
    check("ce_gap_overflow", {31'd0, overflow}, 32'd0);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fast_nms_3x3.md
# fast_nms_3x3

3x3 non-maximum suppression stage downstream of the FAST detector top. Consumes the raster-ordered per-pixel stream of corner flag, 13-bit score and pixel coordinates. Keeps only corners whose score is a strict local maximum in their 3x3 neighbourhood, under a fixed raster-order tie-break. Survivors are buffered in an output FIFO and delivered over a valid/ready handshake to the keypoint consumer (descriptor/packer).

## Interface
- COL_NUM, 640, image width in pixels; sets line-buffer depth.
- ROW_NUM, 480, image height in pixels.
- SCORE_W, 13, score width.
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 4.
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  input-side enable; when low, no input is accepted and the window/compare pipeline holds.
- in_vld  in  1  input pixel valid (from xy_coord_vld); sampled only when ce=1.
- iscorner  in  1  corner flag, coincident with in_vld.
- score  in  SCORE_W  corner score, coincident with in_vld.
- x_coord  in  10  column of the input pixel, 0..COL_NUM-1.
- y_coord  in  10  row of the input pixel, 0..ROW_NUM-1.
- out_vld  out  1  FIFO head holds a keypoint.
- out_rdy  in  1  consumer accepts; a pop occurs when out_vld && out_rdy.
- out_x  out  10  keypoint column.
- out_y  out  10  keypoint row.
- out_score  out  SCORE_W  keypoint score.
- overflow  out  1  sticky; set when a survivor is dropped because the FIFO is full.
- drop_cnt  out  16  count of dropped survivors; saturates at 0xFFFF.

## Operation
- Accept: a pixel is accepted when ce && in_vld. There is no input backpressure.
- Effective score: s = iscorner ? score : 0. Only s is stored.
- Line buffers:
  - Two buffers, LB1 (row y-1) and LB2 (row y-2), each COL_NUM x SCORE_W, indexed by x_coord.
  - On accept: read LB1[x] and LB2[x], then write LB2[x] <= old LB1[x] and LB1[x] <= s (read-before-write).
  - Buffers are never cleared; stale data is masked by the evaluation rule below.
- Window: a 3x3 register array shifts left by one column on each accept. The new right column is {LB2[x], LB1[x], s}, top to bottom.
- Evaluation: performed only for accepts with x_coord >= 2 and y_coord >= 2.
  - Centre C is at (x_coord-1, y_coord-1).
  - Outermost image ring is never emitted.
  - Window contents from a previous row or frame are never evaluated: x and y resets zero the eligibility.
- Keep rule: C != 0, C > each of UL, U, UR, L (raster predecessors), and C >= each of R, DL, D, DR (raster successors). Exactly one of two equal adjacent maxima survives.
- Comparisons are unsigned, SCORE_W bits.
- Pipeline:
  - Stage 1: window update plus registered centre coordinates and an eligibility flag.
  - Stage 2: compare; registered keep flag with {cx, cy, C}.
  - Stage 3: FIFO write.
- FIFO:
  - First-word-fall-through, FIFO_DEPTH entries of {x, y, score}.
  - Write and pop in the same cycle are legal at any occupancy. When full, a simultaneous pop frees the slot and the write succeeds.
  - Write when full without a pop: entry dropped, overflow <= 1, drop_cnt increments (saturating).
- ce low: stages 1-2 hold and no FIFO write occurs; FIFO pops still proceed.
- Reset (rst=0, async):
  - Window, pipeline registers and FIFO pointers/count go to 0.
  - out_vld=0, out_x=0, out_y=0, out_score=0, overflow=0, drop_cnt=0.
  - Line-buffer contents undefined.
  - Reset mid-frame discards all in-flight and buffered keypoints.

## Timing
- Latency: accept at edge E0 -> keep flag registered at E1 -> FIFO write at E2 -> out_vld=1 after E2 if the FIFO was empty (2-edge latency).
- Sustained throughput: one pixel per clock. Output drain: one keypoint per clock while out_rdy=1.
- out_x, out_y and out_score are stable while out_vld=1 and out_rdy=0.
- out_vld deasserts the cycle after popping the last entry.
- The fifo count must not wrap: full and empty are distinguished by a count of log2(FIFO_DEPTH)+1 bits.

## Test plan
- Isolated corner: only pixel (10,10) has iscorner=1, score=100 in a 640x480 frame -> exactly one output (10,10,100), out_vld rises 2 edges after pixel (11,11) is accepted.
- Tie, horizontal: (20,5) and (21,5) both score 50 -> only (20,5) emitted. Tie, vertical: (30,8) and (30,9) both 50 -> only (30,8) emitted.
- Border: corners at (0,3), (639,3), (5,0) and (5,479), score 200 -> no output. Corner at (1,1) score 200 -> output (1,1,200).
- Backpressure/overflow: FIFO_DEPTH=4, out_rdy=0, six isolated corners -> 4 held in order, overflow=1, drop_cnt=2. Raise out_rdy -> 4 pops in raster order, then out_vld=0.
- ce gating: ce low for 5 cycles mid-row with in_vld=1 -> no accepts, and output equals the same frame streamed without gaps.
- Async reset mid-frame with 3 entries queued -> out_vld=0 and drop_cnt=0 immediately. The next full frame yields the same output as a clean run.
